if_fetch_unit: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake. Memory latency is variable.
- Presents instruction_out and pc_out (fetched PC + 4) to the IF/ID register, or a NOP bubble when nothing is ready.
- Handles freeze back-pressure from the hazard unit and branch redirects from EXE, including a redirect that arrives while a fetch is in flight.

---
 rtl/if_fetch_unit.sv | 121 ++++++++++++
 tb/tb_if_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over req/ack,
// and feeds the IF/ID register with a freeze buffer and branch redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] tgt_q, tgt_d;
    logic        redir_q, redir_d;

    logic [31:0] target;
    logic [31:0] next_addr;

    assign target    = {branch_addr[31:2], 2'b00};
    assign next_addr = req_addr_q + 32'd4;

    // State, fetch address, freeze buffer and deferred redirect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_addr_q <= {RESET_PC[31:2], 2'b00};
            buf_q      <= 32'd0;
            tgt_q      <= 32'd0;
            redir_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
            tgt_q      <= tgt_d;
            redir_q    <= redir_d;
        end
    end

    // Next-state and output decode; a branch always wins over freeze.
    always_comb begin
        state_d         = state_q;
        req_addr_d      = req_addr_q;
        buf_d           = buf_q;
        tgt_d           = tgt_q;
        redir_d         = redir_q;
        mem_req         = 1'b0;
        mem_addr        = req_addr_q;
        if_valid        = 1'b0;
        instruction_out = NOP_INSTR;
        pc_out          = 32'd0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
                if (branch_taken) begin
                    req_addr_d = target;
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (branch_taken) begin
                        req_addr_d = target;
                        redir_d    = 1'b0;
                    end else if (redir_q) begin
                        req_addr_d = tgt_q;
                        redir_d    = 1'b0;
                    end else if (!freeze) begin
                        if_valid        = 1'b1;
                        instruction_out = mem_rdata;
                        pc_out          = next_addr;
                        req_addr_d      = next_addr;
                    end else begin
                        buf_d   = mem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (branch_taken) begin
                    // The in-flight request must finish at its old address.
                    tgt_d   = target;
                    redir_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    buf_d      = 32'd0;
                    req_addr_d = target;
                    state_d    = S_WAIT;
                end else begin
                    if_valid        = 1'b1;
                    instruction_out = buf_q;
                    pc_out          = next_addr;
                    if (!freeze) begin
                        req_addr_d = next_addr;
                        state_d    = S_WAIT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency memory, directed scenarios,
// and a random phase checked against an instruction-stream model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, branch_taken, spur;
    logic [31:0] branch_addr;
    logic        mem_req, mem_ack, if_valid;
    logic [31:0] mem_addr, mem_rdata, instruction_out, pc_out;
    logic        mem_req1, if_valid1;
    logic [31:0] mem_addr1, instr1, pc1;

    int n_tests = 0;
    int n_fail  = 0;
    int minlat  = 0;
    int maxlat  = 0;
    logic [3:0] lat, cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    if_fetch_unit #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .instruction_out(instruction_out),
        .pc_out(pc_out)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut1 (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .mem_req(mem_req1), .mem_addr(mem_addr1),
        .mem_ack(mem_req1), .mem_rdata(fmem(mem_addr1)),
        .if_valid(if_valid1), .instruction_out(instr1),
        .pc_out(pc1)
    );

    // Memory: ack after 'lat' waiting cycles; stray acks when idle.
    assign mem_ack   = mem_req ? (cnt == lat) : spur;
    assign mem_rdata = fmem(mem_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
            lat <= 4'($urandom_range(maxlat, minlat));
        end else if (!mem_req) begin
            cnt <= 4'd0;
        end else if (mem_ack) begin
            cnt <= 4'd0;
            lat <= 4'($urandom_range(maxlat, minlat));
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    // Stream model: consumed instructions must follow the program order.
    initial begin
        logic [31:0] exp_pc, prev_addr, prev_pc, prev_ins;
        logic        prev_pend, prev_vf;
        exp_pc = 0; prev_addr = 0; prev_pc = 0; prev_ins = 0;
        prev_pend = 0; prev_vf = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc = 0; prev_pend = 0; prev_vf = 0;
            end else begin
                if (prev_pend) begin
                    chk("req_hold", mem_req, 1);
                    chk("addr_hold", mem_addr, prev_addr);
                end
                if (mem_req) chk("align", mem_addr[1:0], 0);
                if (prev_vf && !branch_taken) begin
                    chk("frz_v", if_valid, 1);
                    chk("frz_pc", pc_out, prev_pc);
                    chk("frz_ins", instruction_out, prev_ins);
                end
                if (!if_valid) begin
                    chk("bub_ins", instruction_out, NOP);
                    chk("bub_pc", pc_out, 0);
                end
                if (branch_taken) begin
                    chk("br_bubble", if_valid, 0);
                    exp_pc = {branch_addr[31:2], 2'b00};
                end else if (if_valid && !freeze) begin
                    chk("pc", pc_out, exp_pc + 32'd4);
                    chk("ins", instruction_out, fmem(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
                prev_pend = mem_req && !mem_ack;
                prev_addr = mem_addr;
                prev_vf   = if_valid && freeze && !branch_taken;
                prev_pc   = pc_out;
                prev_ins  = instruction_out;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lo, input int hi);
        minlat = lo;
        maxlat = hi;
        freeze = 0;
        branch_taken = 0;
        spur = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic wait_req(input logic [31:0] a);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == a) begin
                ok = 1;
                break;
            end
        end
        chk("to_req", ok, 1);
    endtask

    task automatic after_branch(input logic [31:0] old,
                                input logic [31:0] xaddr,
                                input logic [31:0] forbid);
        bit seen_new = 0;
        bit seen_v = 0;
        int bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == forbid) bad++;
            if (!seen_new && mem_req && mem_addr != old) begin
                seen_new = 1;
                chk("new_addr", mem_addr, xaddr);
            end
            if (if_valid) begin
                seen_v = 1;
                chk("first_pc", pc_out, xaddr + 32'd4);
                chk("first_ins", instruction_out, fmem(xaddr));
                break;
            end
        end
        chk("to_br", seen_v, 1);
        chk("forbid", bad, 0);
    endtask

    task automatic rand_phase(input int lo, input int hi, input int n);
        do_reset(lo, hi);
        for (int i = 0; i < n; i++) begin
            step();
            freeze       = ($urandom % 4) == 0;
            branch_taken = ($urandom % 12) == 0;
            branch_addr  = ($urandom % 3 == 0) ?
                           (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            spur         = ($urandom % 3) == 0;
        end
        step();
        freeze = 0;
        branch_taken = 0;
        spur = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; freeze = 0; branch_taken = 0; branch_addr = 0; spur = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_v", if_valid, 0);
        chk("rst_ins", instruction_out, NOP);
        chk("rst_pc", pc_out, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_req", mem_req, 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("tp_v", if_valid, 1);
            chk("tp_pc", pc_out, 32'(4 * k));
        end

        do_reset(3, 3);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("w_req", mem_req, 1);
            chk("w_v", if_valid, 0);
            chk("w_addr", mem_addr, 0);
        end
        @(negedge clk);
        chk("ack_v", if_valid, 1);
        chk("ack_pc", pc_out, 32'h4);
        chk("ack_ins", instruction_out, fmem(0));
        chk("ack_addr", mem_addr, 0);

        do_reset(0, 0);
        repeat (3) @(negedge clk);
        step();
        freeze = 1;
        @(negedge clk);
        chk("f_req", mem_req, 1);
        chk("f_addr", mem_addr, 32'h8);
        step();
        @(negedge clk);
        chk("h_req", mem_req, 0);
        chk("h_v", if_valid, 1);
        chk("h_pc", pc_out, 32'hC);
        chk("h_ins", instruction_out, fmem(32'h8));
        step();
        freeze = 0;
        @(negedge clk);
        chk("h2_req", mem_req, 0);
        chk("h2_pc", pc_out, 32'hC);
        step();
        @(negedge clk);
        chk("nx_req", mem_req, 1);
        chk("nx_addr", mem_addr, 32'hC);

        do_reset(3, 3);
        wait_req(32'h10);
        step();
        branch_taken = 1;
        branch_addr = 32'h103;
        @(negedge clk);
        chk("b_v", if_valid, 0);
        chk("b_addr", mem_addr, 32'h10);
        step();
        branch_taken = 0;
        after_branch(32'h10, 32'h100, 32'h14);

        do_reset(3, 3);
        @(negedge clk);
        step();
        branch_taken = 1;
        branch_addr = 32'h200;
        step();
        branch_addr = 32'h300;
        step();
        branch_taken = 0;
        after_branch(32'h0, 32'h300, 32'h200);

        do_reset(0, 0);
        @(negedge clk);
        chk("w_idle1", mem_req1, 0);
        @(negedge clk);
        chk("w_v1", if_valid1, 1);
        chk("w_pc1", pc1, 32'h0);
        chk("w_ins1", instr1, fmem(32'hFFFF_FFFC));
        @(negedge clk);
        chk("w_addr1", mem_addr1, 32'h0);
        chk("w_pc1b", pc1, 32'h4);

        do_reset(5, 5);
        repeat (3) @(negedge clk);
        chk("mid_req", mem_req, 1);
        #1 rst = 1;
        #1;
        chk("ab_req", mem_req, 0);
        chk("ab_v", if_valid, 0);
        chk("ab_ins", instruction_out, NOP);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        rand_phase(0, 3, 800);
        rand_phase(0, 0, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
